// File: rtl/spi_controller_single_clk.sv
// Single-clock SPI mode-0 controller: one byte per start, optional chip-select hold between bytes.
// Define SPI_CTRL_LSB_FIRST_EN to shift out and assemble LSB first (default MSB first).
module spi_controller_single_clk #(
  parameter int unsigned BYTE_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              keep_cs,
  input  logic              cs_release,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] rx_data,
  output logic              csn_pad,
  output logic              sck_pad,
  output logic              mosi_pad,
  input  logic              miso_pad
);

  localparam int unsigned     BitW    = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam int unsigned     DivW    = $clog2(CLK_DIV);
  localparam logic [BitW-1:0] LastBit = BitW'(BYTE_W - 1);
  localparam logic [DivW-1:0] DivLoad = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StSckHi, StSckLo, StLast, StHeld, StGap
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [BYTE_W-1:0] tx_q, tx_d;
  logic [BYTE_W-1:0] rxs_q, rxs_d;
  logic [BYTE_W-1:0] rx_q, rx_d;
  logic              csn_q, csn_d;
  logic              sck_q, sck_d;
  logic              done_q, done_d;

  logic              tick;
  logic              cur_bit;
  logic [BYTE_W-1:0] tx_adv;
  logic [BYTE_W-1:0] rxs_in;

  // tx_q keeps the bit currently on the wire at its output end; it advances on SCK falls.
`ifdef SPI_CTRL_LSB_FIRST_EN
  assign cur_bit = tx_q[0];
  assign tx_adv  = tx_q >> 1;
  assign rxs_in  = {miso_pad, rxs_q[BYTE_W-1:1]};
`else
  assign cur_bit = tx_q[BYTE_W-1];
  assign tx_adv  = tx_q << 1;
  assign rxs_in  = {rxs_q[BYTE_W-2:0], miso_pad};
`endif

  assign tick = (div_q == '0);

  always_comb begin
    state_d = state_q;
    div_d   = tick ? div_q : div_q - 1'b1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rxs_d   = rxs_q;
    rx_d    = rx_q;
    csn_d   = csn_q;
    sck_d   = sck_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle, StHeld: begin
        // start wins over a simultaneous cs_release in HELD
        if (start) begin
          tx_d    = tx_data;
          bit_d   = '0;
          csn_d   = 1'b0;
          div_d   = DivLoad;
          state_d = StSetup;
        end else if (state_q == StHeld && cs_release) begin
          csn_d   = 1'b1;
          div_d   = DivLoad;
          state_d = StGap;
        end
      end
      StSetup, StSckLo: begin
        if (tick) begin
          sck_d   = 1'b1;
          rxs_d   = rxs_in;
          div_d   = DivLoad;
          state_d = StSckHi;
        end
      end
      StSckHi: begin
        if (tick) begin
          sck_d = 1'b0;
          div_d = DivLoad;
          if (bit_q == LastBit) begin
            state_d = StLast;
          end else begin
            tx_d    = tx_adv;
            bit_d   = bit_q + 1'b1;
            state_d = StSckLo;
          end
        end
      end
      StLast: begin
        if (tick) begin
          rx_d   = rxs_q;
          done_d = 1'b1;
          if (keep_cs) begin
            state_d = StHeld;
          end else begin
            csn_d   = 1'b1;
            div_d   = DivLoad;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rxs_q   <= '0;
      rx_q    <= '0;
      csn_q   <= 1'b1;
      sck_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rxs_q   <= rxs_d;
      rx_q    <= rx_d;
      csn_q   <= csn_d;
      sck_q   <= sck_d;
      done_q  <= done_d;
    end
  end

  assign busy     = !(state_q inside {StIdle, StHeld});
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign csn_pad  = csn_q;
  assign sck_pad  = sck_q;
  // Gating with chip select keeps MOSI quiet whenever the bus is deselected.
  assign mosi_pad = !csn_q && cur_bit;

endmodule

// File: tb/tb_spi_controller_single_clk.sv
// Randomized bench for spi_controller_single_clk with a bit-stream reference model.
// Honours SPI_CTRL_LSB_FIRST_EN in the model so both bit orders can be exercised.
module tb_spi_controller_single_clk;
  localparam int W      = 8;
  localparam int D      = 4;
  localparam int Budget = 4 * (2 * W + 2) * D;

  logic         sys_clk;
  logic         sys_rst, start, keep_cs, cs_release;
  logic [W-1:0] tx_data, rx_data;
  logic         busy, done, csn_pad, sck_pad, mosi_pad, miso_pad;

  int   miso_mode = 0;  // 0 loopback, 1 held high, 2 random per bit
  logic miso_rand = 1'b0;
  assign miso_pad = (miso_mode == 0) ? mosi_pad : (miso_mode == 1) ? 1'b1 : miso_rand;

  spi_controller_single_clk #(.BYTE_W(W), .CLK_DIV(D)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .tx_data    (tx_data),
    .keep_cs    (keep_cs),
    .cs_release (cs_release),
    .busy       (busy),
    .done       (done),
    .rx_data    (rx_data),
    .csn_pad    (csn_pad),
    .sck_pad    (sck_pad),
    .mosi_pad   (mosi_pad),
    .miso_pad   (miso_pad)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Bus monitor: records what a slave would see at each SCK rising edge.
  int   rise_cyc[$];
  logic mosi_bits[$];
  logic miso_bits[$];
  int   done_cnt = 0;
  int   csn_high_cnt = 0;
  int   mosi_idle_viol = 0;
  logic sck_prev = 1'b0;

  always @(negedge sys_clk) begin
    if (sck_pad && !sck_prev) begin
      rise_cyc.push_back(cyc);
      mosi_bits.push_back(mosi_pad);
      miso_bits.push_back(miso_pad);
      miso_rand = 1'($urandom_range(1, 0));
    end
    sck_prev = sck_pad;
    if (done) done_cnt++;
    if (csn_pad) csn_high_cnt++;
    if (csn_pad && mosi_pad) mosi_idle_viol++;
  end

  function automatic logic exp_mosi(input logic [W-1:0] tx, input int i);
`ifdef SPI_CTRL_LSB_FIRST_EN
    return tx[i];
`else
    return tx[W-1-i];
`endif
  endfunction

  // Byte a slave-side shift register would hold after W samples starting at index base.
  function automatic logic [W-1:0] model_rx(input int base);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
`ifdef SPI_CTRL_LSB_FIRST_EN
      r[i] = miso_bits[base+i];
`else
      r[W-1-i] = miso_bits[base+i];
`endif
    end
    return r;
  endfunction

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  int           r0, e0, done_cyc;
  bit           timed_out;
  logic [W-1:0] rx_at_done;
  logic         csn_at_done, busy_at_done;

  // Launches one byte and waits for done; inject pulses a foreign start while SCK is high.
  task automatic run_byte(input logic [W-1:0] tx, input logic keep, input bit inject);
    bit injected;
    injected  = 1'b0;
    r0        = rise_cyc.size();
    start     = 1'b1;
    tx_data   = tx;
    keep_cs   = keep;
    e0        = cyc + 1;
    timed_out = 1'b1;
    for (int n = 0; n < Budget; n++) begin
      step();
      start      = 1'b0;
      cs_release = 1'b0;
      if (n == 0) tx_data = ~tx;
      if (done) begin
        timed_out    = 1'b0;
        done_cyc     = cyc;
        rx_at_done   = rx_data;
        csn_at_done  = csn_pad;
        busy_at_done = busy;
        break;
      end
      if (inject && !injected && sck_pad) begin
        start    = 1'b1;
        tx_data  = ~tx;
        injected = 1'b1;
      end
    end
    keep_cs = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; start = 1'b1; tx_data = '1; keep_cs = 1'b0; cs_release = 1'b0;
    miso_mode = 1;
    repeat (3) step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (csn_pad !== 1'b1) begin miscompares++; $display("FAIL reset_csn got %b want 1", csn_pad); end
    vectors++; if (sck_pad !== 1'b0) begin miscompares++; $display("FAIL reset_sck got %b want 0", sck_pad); end
    vectors++; if (mosi_pad !== 1'b0) begin miscompares++; $display("FAIL reset_mosi got %b want 0", mosi_pad); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (rx_data !== '0) begin miscompares++; $display("FAIL reset_rx got %h want 0", rx_data); end
    sys_rst = 1'b0; start = 1'b0;
    repeat (2) step();
    vectors++; if (busy !== 1'b0 || csn_pad !== 1'b1) begin
      miscompares++; $display("FAIL reset_idle busy=%b csn=%b want 0/1", busy, csn_pad);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] tx_tab[8];
    int           mode_tab[8];
    tx_tab[0] = 8'hA5; mode_tab[0] = 0;
    tx_tab[1] = 8'h3C; mode_tab[1] = 1;
    for (int i = 2; i < 8; i++) begin
      tx_tab[i]   = W'($urandom);
      mode_tab[i] = int'($urandom_range(2, 0));
    end
    for (int t = 0; t < 8; t++) begin
      miso_mode = mode_tab[t];
      run_byte(tx_tab[t], 1'b0, 1'b0);
      vectors++; if (timed_out) begin miscompares++; $display("FAIL stream%0d_timeout no done", t); end
      vectors++; if (rise_cyc.size() - r0 !== W) begin
        miscompares++; $display("FAIL stream%0d_rises got %0d want %0d", t, rise_cyc.size() - r0, W);
      end
      for (int k = 1; k <= W && r0 + k <= rise_cyc.size(); k++) begin
        vectors++; if (rise_cyc[r0+k-1] - e0 !== (2 * k - 1) * D) begin
          miscompares++;
          $display("FAIL stream%0d_rise%0d_time got %0d want %0d", t, k, rise_cyc[r0+k-1] - e0,
                   (2 * k - 1) * D);
        end
        vectors++; if (mosi_bits[r0+k-1] !== exp_mosi(tx_tab[t], k - 1)) begin
          miscompares++;
          $display("FAIL stream%0d_mosi%0d got %b want %b", t, k, mosi_bits[r0+k-1],
                   exp_mosi(tx_tab[t], k - 1));
        end
      end
      vectors++; if (done_cyc - e0 !== (2 * W + 1) * D) begin
        miscompares++; $display("FAIL stream%0d_done_time got %0d want %0d", t, done_cyc - e0,
                                (2 * W + 1) * D);
      end
      if (rise_cyc.size() - r0 >= W) begin
        vectors++; if (rx_at_done !== model_rx(r0)) begin
          miscompares++; $display("FAIL stream%0d_rx got %h want %h", t, rx_at_done, model_rx(r0));
        end
      end
      if (mode_tab[t] == 0) begin
        vectors++; if (rx_at_done !== tx_tab[t]) begin
          miscompares++; $display("FAIL stream%0d_loop_rx got %h want %h", t, rx_at_done, tx_tab[t]);
        end
      end
      if (mode_tab[t] == 1) begin
        vectors++; if (rx_at_done !== {W{1'b1}}) begin
          miscompares++; $display("FAIL stream%0d_high_rx got %h want ff", t, rx_at_done);
        end
      end
      vectors++; if (csn_at_done !== 1'b1 || busy_at_done !== 1'b1) begin
        miscompares++; $display("FAIL stream%0d_gap_entry csn=%b busy=%b want 1/1", t, csn_at_done,
                                busy_at_done);
      end
      repeat (D - 1) step();
      vectors++; if (busy !== 1'b1 || csn_pad !== 1'b1) begin
        miscompares++; $display("FAIL stream%0d_gap_hold busy=%b csn=%b want 1/1", t, busy, csn_pad);
      end
      step();
      vectors++; if (busy !== 1'b0) begin
        miscompares++; $display("FAIL stream%0d_gap_end busy got %b want 0", t, busy);
      end
      repeat (2) step();
    end
  endtask

  task automatic test_held();
    int ch0, dc0;
    miso_mode = 0;
    ch0 = csn_high_cnt;
    dc0 = done_cnt;
    run_byte(8'h12, 1'b1, 1'b0);
    vectors++; if (timed_out || rx_at_done !== 8'h12) begin
      miscompares++; $display("FAIL held_rx1 got %h want 12 (timeout=%0b)", rx_at_done, timed_out);
    end
    vectors++; if (csn_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
      miscompares++; $display("FAIL held_entry csn=%b busy=%b want 0/0", csn_at_done, busy_at_done);
    end
    repeat (3) step();
    vectors++; if (busy !== 1'b0 || csn_pad !== 1'b0 || sck_pad !== 1'b0) begin
      miscompares++; $display("FAIL held_idle busy=%b csn=%b sck=%b want 0/0/0", busy, csn_pad, sck_pad);
    end
    cs_release = 1'b1;  // start must win
    run_byte(8'h34, 1'b1, 1'b0);
    vectors++; if (timed_out || rx_at_done !== 8'h34) begin
      miscompares++; $display("FAIL held_rx2 got %h want 34 (timeout=%0b)", rx_at_done, timed_out);
    end
    vectors++; if (done_cyc - e0 !== (2 * W + 1) * D) begin
      miscompares++; $display("FAIL held_done_time got %0d want %0d", done_cyc - e0, (2 * W + 1) * D);
    end
    vectors++; if (csn_high_cnt - ch0 !== 0) begin
      miscompares++; $display("FAIL held_csn_cont got %0d high cycles want 0", csn_high_cnt - ch0);
    end
    vectors++; if (done_cnt - dc0 !== 2) begin
      miscompares++; $display("FAIL held_done_cnt got %0d want 2", done_cnt - dc0);
    end
    step();
    cs_release = 1'b1;
    step();
    cs_release = 1'b0;
    vectors++; if (csn_pad !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL held_release csn=%b busy=%b want 1/1", csn_pad, busy);
    end
    repeat (D - 1) step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL held_gap busy got %b want 1", busy); end
    step();
    vectors++; if (busy !== 1'b0 || csn_pad !== 1'b1) begin
      miscompares++; $display("FAIL held_gap_end busy=%b csn=%b want 0/1", busy, csn_pad);
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] tx;
    int           rn;
    miso_mode = 0;
    tx = W'($urandom);
    run_byte(tx, 1'b0, 1'b1);
    vectors++; if (timed_out || rx_at_done !== tx) begin
      miscompares++; $display("FAIL ignore_rx got %h want %h (timeout=%0b)", rx_at_done, tx, timed_out);
    end
    vectors++; if (done_cyc - e0 !== (2 * W + 1) * D) begin
      miscompares++; $display("FAIL ignore_done_time got %0d want %0d", done_cyc - e0, (2 * W + 1) * D);
    end
    vectors++; if (rise_cyc.size() - r0 !== W) begin
      miscompares++; $display("FAIL ignore_rises got %0d want %0d", rise_cyc.size() - r0, W);
    end
    step();
    start = 1'b1; tx_data = ~tx;
    step();
    start = 1'b0;
    rn = rise_cyc.size();
    repeat (D) step();
    vectors++; if (busy !== 1'b0 || csn_pad !== 1'b1) begin
      miscompares++; $display("FAIL ignore_gap busy=%b csn=%b want 0/1", busy, csn_pad);
    end
    repeat (2 * D) step();
    vectors++; if (rise_cyc.size() !== rn || busy !== 1'b0) begin
      miscompares++; $display("FAIL ignore_gap_start rises=%0d busy=%b want %0d/0", rise_cyc.size(), busy, rn);
    end
  endtask

  task automatic test_reset_mid();
    int rb, dc0;
    bit reached;
    miso_mode = 2;
    dc0 = done_cnt;
    rb  = rise_cyc.size();
    start = 1'b1; tx_data = W'($urandom);
    step();
    start = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < Budget; n++) begin
      if (rise_cyc.size() - rb >= 4) begin reached = 1'b1; break; end
      step();
    end
    vectors++; if (!reached) begin miscompares++; $display("FAIL rstmid_timeout rise 4 not seen"); end
    sys_rst = 1'b1; start = 1'b1;
    step();
    sys_rst = 1'b0; start = 1'b0;
    vectors++; if (csn_pad !== 1'b1 || sck_pad !== 1'b0 || busy !== 1'b0 || mosi_pad !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_pads csn=%b sck=%b busy=%b mosi=%b want 1/0/0/0", csn_pad, sck_pad, busy, mosi_pad);
    end
    vectors++; if (rx_data !== '0) begin miscompares++; $display("FAIL rstmid_rx got %h want 0", rx_data); end
    repeat (2 * W * D) step();
    vectors++; if (done_cnt - dc0 !== 0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_nodone dones=%0d busy=%b want 0/0", done_cnt - dc0, busy);
    end
  endtask

  task automatic test_mosi_idle();
    vectors++; if (mosi_idle_viol !== 0) begin
      miscompares++; $display("FAIL mosi_idle got %0d cycles with mosi=1 csn=1 want 0", mosi_idle_viol);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_held();
    test_busy_ignore();
    test_reset_mid();
    test_mosi_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_controller_single_clk.md
SPI_CONTROLLER_SINGLE_CLK -- requirements
Module: spi_controller_single_clk

Interface
REQ-001 SHALL have parameter BYTE_W, default 8, bits per transfer.
REQ-002 SHALL have parameter CLK_DIV, default 4, SCK half-period in sys_clk cycles; legal range >= 2.
REQ-003 SHALL have port sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request a byte transfer; sampled only when busy=0.
REQ-006 SHALL have port tx_data  input  BYTE_W  byte to shift out; latched on the accepted start.
REQ-007 SHALL have port keep_cs  input  1  sampled at end of byte; 1 holds csn_pad low for a following byte.
REQ-008 SHALL have port cs_release  input  1  in HELD state, deasserts csn_pad.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until return to IDLE or HELD.
REQ-010 SHALL have port done  output  1  single-cycle pulse when rx_data is updated.
REQ-011 SHALL have port rx_data  output  BYTE_W  last received byte; holds until the next done.
REQ-012 SHALL have port csn_pad  output  1  chip select, active low.
REQ-013 SHALL have port sck_pad  output  1  serial clock; SPI mode 0 (idle low).
REQ-014 SHALL have port mosi_pad  output  1  serial data out.
REQ-015 SHALL have port miso_pad  input  1  serial data in.

Function
REQ-016 States SHALL be IDLE, SETUP, SCK_HI, SCK_LO, LAST, HELD, GAP; one down-counter of CLK_DIV cycles times every non-IDLE/HELD state.
REQ-017 IDLE: csn_pad=1, sck_pad=0, mosi_pad=0; start=1 at edge E0 -> latch tx_data, csn_pad<=0, mosi_pad<=first bit, bit count<=0, go SETUP.
REQ-018 SETUP: after CLK_DIV cycles, sck_pad<=1 and miso_pad sampled into RX shift register in the same edge; go SCK_HI.
REQ-019 SCK_HI: after CLK_DIV cycles, sck_pad<=0; if bit count = BYTE_W-1 go LAST, else mosi_pad<=next bit, bit count+1, go SCK_LO.
REQ-020 SCK_LO: after CLK_DIV cycles, sck_pad<=1, sample miso_pad, go SCK_HI.
REQ-021 MOSI SHALL change only on SCK falling edges (or at E0); MISO SHALL be sampled only on SCK rising edges.
REQ-022 Default bit order SHALL be MSB first for both MOSI and RX assembly.
REQ-023 LAST: after CLK_DIV cycles, rx_data<=RX shift, done=1 for one cycle; keep_cs=1 -> HELD (csn_pad stays 0); keep_cs=0 -> csn_pad<=1, go GAP.
REQ-024 Timing: rising edge k (1..BYTE_W) at E0+(2k-1)*CLK_DIV; done at E0+(2*BYTE_W+1)*CLK_DIV.
REQ-025 GAP: csn_pad=1 for CLK_DIV cycles, then IDLE; start during GAP SHALL be ignored.
REQ-026 HELD: busy=0, csn_pad=0, sck_pad=0; start -> behaves as REQ-017 without a csn_pad edge; cs_release (start=0) -> csn_pad<=1, GAP; start and cs_release simultaneous -> start wins.
REQ-027 start while busy=1 SHALL be ignored with no effect on the transfer in progress.
REQ-028 mosi_pad SHALL be 0 whenever csn_pad=1.

Reset
REQ-029 On sys_rst=1 at any edge: state IDLE, csn_pad=1, sck_pad=0, mosi_pad=0, busy=0, done=0, rx_data=0, counters=0.
REQ-030 Reset mid-transfer SHALL abort with no done pulse and no partial rx_data update.
REQ-031 Reset SHALL override start in the same cycle.

Configuration
REQ-032 Macro SPI_CTRL_LSB_FIRST_EN defined: MOSI sends bit 0 first and RX assembles LSB first; undefined: MSB first per REQ-022; timing unchanged.

Verification
REQ-033 CLK_DIV=4, start with tx_data=0xA5, miso looped to mosi -> 8 SCK pulses, done at E0+68, rx_data=0xA5, csn_pad high 1 cycle later.
REQ-034 miso held 1, tx_data=0x3C -> MOSI bit stream 0,0,1,1,1,1,0,0 at rising edges; rx_data=0xFF.
REQ-035 keep_cs=1 for 0x12 then start 0x34 in HELD -> csn_pad low continuously across both bytes; two done pulses; cs_release -> csn_pad=1, GAP 4 cycles, busy=0.
REQ-036 sys_rst at rising edge 4 of a transfer -> next cycle csn_pad=1, sck_pad=0, busy=0; no done; rx_data=0.
REQ-037 start pulsed during SCK_HI and during GAP -> ignored; in-flight byte completes identically.
REQ-038 SPI_CTRL_LSB_FIRST_EN defined, tx_data=0x01 looped back -> first MOSI bit 1, rx_data=0x01.
